multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Sequential control unit for the multi-cycle RV32I core variant.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and waits on a memory-ready handshake.
- Generates per-state datapath strobes, counts retired instructions, and traps on illegal encodings or memory timeout.
- Sits between the instruction register and the shared datapath/memory port; it replaces the single-cycle combinational decoder in this core.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive not-ready cycles in FETCH or MEM before trapping; 0 disables the timeout.
- TO_W, 4: width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.
- RET_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0]; stable from DECODE until the next FETCH.
- funct3  in  3  IR[14:12].
- mem_ready  in  1  memory has completed the current read or write this cycle.
- br_taken  in  1  branch condition from the ALU; sampled in EXEC.
- halt_req  in  1  request to stop at the next instruction boundary.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg  out  1 each  datapath strobes.
- ALUSrc1  out  1  ALU operand-1 select: 0=rs1, 1=PC.
- ALUSrc2  out  2  ALU operand-2 select: 00=rs2, 01=imm, 10=const 4.
- ALUOp  out  7  ALU operation code (the opcode itself).
- Concat_control  out  3  immediate format: 000 R, 001 U, 010 J, 011 I, 100 B, 101 S, 110 shamt.
- BE  out  4  byte enables.
- PCSrc  out  2  next-PC select: 00 PC+4, 01 branch target, 10 JAL target, 11 JALR target with bit0 cleared.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- retired  out  RET_W  retired-instruction count; wraps modulo 2^RET_W.
- illegal  out  1  sticky flag: illegal-instruction trap.
- mem_timeout  out  1  sticky flag: memory-timeout trap.
- halted  out  1  high while in HALT.

Behaviour:
- Reset: state=FETCH, wait counter=0, retired=0, illegal=0, mem_timeout=0.
  - While RST=1, every strobe, instr_done and halted are forced to 0 and BE=0000.
  - RST asserted in any state, including mid-wait, HALT or TRAP, takes effect at the next edge.
- Strobes are combinational from the state register plus opcode/funct3/br_taken. Strobes not listed for a state are 0.
- FETCH:
  - MemRead=1, BE=1111.
  - If mem_ready: IRWrite=1, go to DECODE, clear the wait counter.
  - Otherwise increment the wait counter.
- DECODE:
  - Legal opcodes: LUI, AUIPC, OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR.
  - Illegal if the opcode is not in that set, or LOAD funct3 ∈ {3,6,7}, or STORE funct3 > 2. Illegal goes to TRAP and sets illegal.
  - Otherwise go to EXEC.
  - Concat_control/ALUSrc/ALUOp are valid from DECODE through WB:
    - OP-IMM uses 110 when funct3 ∈ {1,5}, otherwise 011.
    - LUI ALUSrc2=01; AUIPC ALUSrc1=1, ALUSrc2=01.
    - JAL ALUSrc1=1, ALUSrc2=10; JALR ALUSrc1=0, ALUSrc2=10.
- EXEC:
  - LOAD/STORE go to MEM.
  - BRANCH: PCWrite=1, PCSrc = br_taken ? 01 : 00; retire; go to FETCH.
  - All other opcodes go to WB.
- MEM:
  - LOAD: MemRead=1. STORE: MemWrite=1.
  - BE by funct3[1:0]: 00→0001, 01→0011, 10→1111.
  - On mem_ready: LOAD goes to WB; STORE sets PCWrite=1, PCSrc=00, retires, goes to FETCH.
  - Otherwise increment the wait counter.
  - Strobes stay asserted for every wait cycle.
- WB:
  - RegWrite=1; MemtoReg=1 only for LOAD.
  - PCWrite=1; PCSrc = 10 for JAL, 11 for JALR, else 00.
  - Retire; go to FETCH.
- Retire:
  - instr_done=1 for that one cycle; retired increments at the edge.
  - Next state is HALT instead of FETCH if halt_req=1 in the retiring cycle.
- HALT: halted=1, no strobes; leaves only on RST. halt_req outside a retiring cycle has no effect.
- Timeout:
  - With MEM_TIMEOUT>0, the wait counter reaching MEM_TIMEOUT while still not ready goes to TRAP and sets mem_timeout.
  - A ready arriving on the same edge wins.
  - The counter clears on every state change.
- TRAP: no strobes; stays until RST; the sticky flags hold.
- Simultaneous events: illegal has priority over halt (no retire). The retired counter wraps from all-ones to 0 silently.

Test Plan:
- R-type ADD with mem_ready tied 1 → states 0,1,2,4,0; RegWrite=1 only in WB; instr_done pulses once; retired=1; 4 cycles per instruction.
- LW with mem_ready low 3 cycles in MEM → MemRead=1, BE=1111 held for 4 MEM cycles; MemtoReg=1 in WB; no timeout.
- Taken then not-taken BEQ (br_taken=1, then 0) → EXEC has PCWrite=1 with PCSrc=01, then PCSrc=00; no RegWrite; each retires in 3 cycles.
- opcode=7'b1111111, and separately SW with funct3=3 → TRAP in the cycle after DECODE; illegal=1; retired unchanged; a RST pulse returns to FETCH with flags cleared.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH → TRAP after 16 FETCH cycles, mem_timeout=1. Repeat with ready on cycle 16 → DECODE, no trap.
- halt_req=1 during the WB of a JAL → PCSrc=10, retired increments, state=HALT with halted=1; strobes stay 0 for 10 more cycles; RST mid-HALT → FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Signal bundle between the multi-cycle control unit (master) and the
// instruction-register / datapath / memory side (slave).
interface multicycle_control_if #(
    parameter int unsigned RET_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             mem_ready;
    logic             br_taken;
    logic             halt_req;

    logic [2:0]       state;
    logic             PCWrite;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             RegWrite;
    logic             MemtoReg;
    logic             ALUSrc1;
    logic [1:0]       ALUSrc2;
    logic [6:0]       ALUOp;
    logic [2:0]       Concat_control;
    logic [3:0]       BE;
    logic [1:0]       PCSrc;
    logic             instr_done;
    logic [RET_W-1:0] retired;
    logic             illegal;
    logic             mem_timeout;
    logic             halted;

    modport master (
        input  opcode, funct3, mem_ready, br_taken, halt_req,
        output state, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg,
               ALUSrc1, ALUSrc2, ALUOp, Concat_control, BE, PCSrc,
               instr_done, retired, illegal, mem_timeout, halted
    );

    modport slave (
        output opcode, funct3, mem_ready, br_taken, halt_req,
        input  state, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg,
               ALUSrc1, ALUSrc2, ALUOp, Concat_control, BE, PCSrc,
               instr_done, retired, illegal, mem_timeout, halted
    );
endinterface

// File: rtl/multicycle_control.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core: datapath
// strobes, retire counting, illegal-opcode and memory-timeout traps.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4,
    parameter int unsigned RET_W       = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    state_t            r_state;
    logic [TO_W-1:0]   r_wait;
    logic [RET_W-1:0]  r_retired;
    logic              r_illegal;
    logic              r_timeout;

    logic   w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
    logic   w_legal_op, w_illegal, w_wait_expired, w_retire;
    state_t w_retire_to;

    assign w_is_load   = (bus.opcode == OPC_LOAD);
    assign w_is_store  = (bus.opcode == OPC_STORE);
    assign w_is_branch = (bus.opcode == OPC_BRANCH);
    assign w_is_jal    = (bus.opcode == OPC_JAL);
    assign w_is_jalr   = (bus.opcode == OPC_JALR);
    assign w_legal_op  = w_is_load || w_is_store || w_is_branch || w_is_jal || w_is_jalr ||
                         (bus.opcode == OPC_LUI) || (bus.opcode == OPC_AUIPC) ||
                         (bus.opcode == OPC_OP)  || (bus.opcode == OPC_OPIMM);
    assign w_illegal   = !w_legal_op ||
                         (w_is_load  && (bus.funct3 == 3'd3 || bus.funct3 >= 3'd6)) ||
                         (w_is_store && (bus.funct3 > 3'd2));

    // Only consulted while not ready, so a ready on the expiring cycle still wins.
    assign w_wait_expired = (MEM_TIMEOUT != 0) && (r_wait == TO_W'(MEM_TIMEOUT));
    assign w_retire_to    = bus.halt_req ? S_HALT : S_FETCH;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_retire)
                r_retired <= r_retired + 1'b1;
            case (r_state)
                S_FETCH, S_MEM: begin
                    if (bus.mem_ready) begin
                        r_wait <= '0;
                        if (r_state == S_FETCH)
                            r_state <= S_DECODE;
                        else
                            r_state <= w_is_load ? S_WB : w_retire_to;
                    end else if (w_wait_expired) begin
                        r_wait    <= '0;
                        r_state   <= S_TRAP;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_illegal) begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_load || w_is_store)
                        r_state <= S_MEM;
                    else if (w_is_branch)
                        r_state <= w_retire_to;
                    else
                        r_state <= S_WB;
                end
                S_WB:           r_state <= w_retire_to;
                S_HALT, S_TRAP: r_state <= r_state;
                default:        r_state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        bus.PCWrite        = 1'b0;
        bus.IRWrite        = 1'b0;
        bus.MemRead        = 1'b0;
        bus.MemWrite       = 1'b0;
        bus.RegWrite       = 1'b0;
        bus.MemtoReg       = 1'b0;
        bus.ALUSrc1        = 1'b0;
        bus.ALUSrc2        = 2'b00;
        bus.ALUOp          = '0;
        bus.Concat_control = 3'b000;
        bus.BE             = '0;
        bus.PCSrc          = 2'b00;
        bus.halted         = 1'b0;
        w_retire           = 1'b0;
        if (!RST) begin
            case (r_state)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.BE      = '1;
                    bus.IRWrite = bus.mem_ready;
                end
                S_EXEC: begin
                    if (w_is_branch) begin
                        bus.PCWrite = 1'b1;
                        bus.PCSrc   = bus.br_taken ? 2'b01 : 2'b00;
                        w_retire    = 1'b1;
                    end
                end
                S_MEM: begin
                    bus.MemRead  = w_is_load;
                    bus.MemWrite = w_is_store;
                    case (bus.funct3[1:0])
                        2'b00:   bus.BE = 4'b0001;
                        2'b01:   bus.BE = 4'b0011;
                        2'b10:   bus.BE = 4'b1111;
                        default: bus.BE = 4'b0000;
                    endcase
                    if (w_is_store && bus.mem_ready) begin
                        bus.PCWrite = 1'b1;
                        w_retire    = 1'b1;
                    end
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = w_is_load;
                    bus.PCWrite  = 1'b1;
                    bus.PCSrc    = w_is_jal ? 2'b10 : (w_is_jalr ? 2'b11 : 2'b00);
                    w_retire     = 1'b1;
                end
                S_HALT:  bus.halted = 1'b1;
                default: ;
            endcase
            if (r_state == S_DECODE || r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
                bus.ALUOp = bus.opcode;
                case (bus.opcode)
                    OPC_LUI:    begin bus.ALUSrc2 = 2'b01; bus.Concat_control = 3'b001; end
                    OPC_AUIPC:  begin bus.ALUSrc1 = 1'b1; bus.ALUSrc2 = 2'b01; bus.Concat_control = 3'b001; end
                    OPC_JAL:    begin bus.ALUSrc1 = 1'b1; bus.ALUSrc2 = 2'b10; bus.Concat_control = 3'b010; end
                    OPC_JALR:   begin bus.ALUSrc2 = 2'b10; bus.Concat_control = 3'b011; end
                    OPC_OPIMM:  begin
                        bus.ALUSrc2        = 2'b01;
                        bus.Concat_control = (bus.funct3 == 3'd1 || bus.funct3 == 3'd5) ? 3'b110 : 3'b011;
                    end
                    OPC_LOAD:   begin bus.ALUSrc2 = 2'b01; bus.Concat_control = 3'b011; end
                    OPC_STORE:  begin bus.ALUSrc2 = 2'b01; bus.Concat_control = 3'b101; end
                    OPC_BRANCH: bus.Concat_control = 3'b100;
                    default:    ;
                endcase
            end
        end
    end

    assign bus.state       = r_state;
    assign bus.instr_done  = w_retire;
    assign bus.retired     = r_retired;
    assign bus.illegal     = r_illegal;
    assign bus.mem_timeout = r_timeout;
endmodule
